// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the ID-stage branch resolution logic.
//   - brsel operand-source encodings (register file / EX / MEM)
//   - funct3 branch condition codes
//   - branch resolution FSM state type
package pipe_pkg;

    // Operand source selects produced by the branch forwarding unit.
    // 2'b11 is unused by the forwarding unit and falls back to the regfile.
    localparam logic [1:0] BRSEL_RF  = 2'b00;
    localparam logic [1:0] BRSEL_EX  = 2'b01;
    localparam logic [1:0] BRSEL_MEM = 2'b10;

    // Conditional branch funct3 codes (010/011 are not branches: never taken)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        ST_RESOLVE = 1'b0,
        ST_STALL   = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: bundles the ID-stage branch resolution signals.
//   master modport: pipeline side (drives instruction/operand info,
//                   receives stall/redirect/flush/target/counters)
//   slave modport : branch_resolve side
interface branch_resolve_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             i_ifid_valid;
    logic [XLEN-1:0]  i_ifid_pc;
    logic             i_br;
    logic             i_jal;
    logic             i_jalr;
    logic [2:0]       i_funct3;
    logic [XLEN-1:0]  i_imm;
    logic [XLEN-1:0]  i_rs1_data;
    logic [XLEN-1:0]  i_rs2_data;
    logic [1:0]       i_rs1_brsel;
    logic [1:0]       i_rs2_brsel;
    logic [XLEN-1:0]  i_idex_alu_data;
    logic             i_idex_memrd;
    logic [XLEN-1:0]  i_exmem_data;
    logic             i_exmem_memrd;
    logic             o_stall;
    logic             o_redirect;
    logic [XLEN-1:0]  o_target;
    logic             o_flush_ifid;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_taken_cnt;

    modport master (
        output i_ifid_valid, i_ifid_pc, i_br, i_jal, i_jalr, i_funct3, i_imm,
               i_rs1_data, i_rs2_data, i_rs1_brsel, i_rs2_brsel,
               i_idex_alu_data, i_idex_memrd, i_exmem_data, i_exmem_memrd,
        input  o_stall, o_redirect, o_target, o_flush_ifid, o_br_cnt, o_taken_cnt
    );

    modport slave (
        input  i_ifid_valid, i_ifid_pc, i_br, i_jal, i_jalr, i_funct3, i_imm,
               i_rs1_data, i_rs2_data, i_rs1_brsel, i_rs2_brsel,
               i_idex_alu_data, i_idex_memrd, i_exmem_data, i_exmem_memrd,
        output o_stall, o_redirect, o_target, o_flush_ifid, o_br_cnt, o_taken_cnt
    );
endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition evaluator.
//   funct3 : branch condition code
//   op_a   : rs1 operand, op_b : rs2 operand
//   taken  : condition holds (0 for non-branch codes 010/011)
module branch_cmp
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            taken
);
    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (op_a == op_b);
    assign lt_s = ($signed(op_a) < $signed(op_b));
    assign lt_u = (op_a < op_b);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch/jump resolution.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : instruction info, operand sources and forwarding
//                    selects in; stall, PC redirect/target, IF/ID flush and
//                    resolved/taken performance counters out.
// A branch whose operand is still being produced by a load holds the front
// end (1 cycle if the load is in MEM, 2 if in EX). After the stall the
// forwarding selects read regfile and the write-through regfile supplies the
// value, so the FSM only needs to count cycles, not remember operands.
module branch_resolve
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    branch_resolve_if.slave bus
);
    br_state_e        state_reg, state_next;
    logic [1:0]       scnt_reg, scnt_next;
    logic [CNT_W-1:0] br_cnt_reg, taken_cnt_reg;

    logic            act;
    logic            use_rs1, use_rs2;
    logic [1:0]      need_rs1, need_rs2, need;
    logic [XLEN-1:0] op1, op2;
    logic            cond;
    logic            taken;
    logic            resolving;

    assign act     = bus.i_ifid_valid & (bus.i_br | bus.i_jal | bus.i_jalr);
    assign use_rs1 = bus.i_br | bus.i_jalr;
    assign use_rs2 = bus.i_br;

    // Stall cycles required by each operand's pending load producer
    always_comb begin
        need_rs1 = 2'd0;
        if (use_rs1 && bus.i_rs1_brsel == BRSEL_EX && bus.i_idex_memrd)
            need_rs1 = 2'd2;
        else if (use_rs1 && bus.i_rs1_brsel == BRSEL_MEM && bus.i_exmem_memrd)
            need_rs1 = 2'd1;

        need_rs2 = 2'd0;
        if (use_rs2 && bus.i_rs2_brsel == BRSEL_EX && bus.i_idex_memrd)
            need_rs2 = 2'd2;
        else if (use_rs2 && bus.i_rs2_brsel == BRSEL_MEM && bus.i_exmem_memrd)
            need_rs2 = 2'd1;
    end

    assign need = (need_rs1 > need_rs2) ? need_rs1 : need_rs2;

    always_comb begin
        op1 = bus.i_rs1_data;
        case (bus.i_rs1_brsel)
            BRSEL_EX:  op1 = bus.i_idex_alu_data;
            BRSEL_MEM: op1 = bus.i_exmem_data;
            default:   op1 = bus.i_rs1_data;
        endcase
        op2 = bus.i_rs2_data;
        case (bus.i_rs2_brsel)
            BRSEL_EX:  op2 = bus.i_idex_alu_data;
            BRSEL_MEM: op2 = bus.i_exmem_data;
            default:   op2 = bus.i_rs2_data;
        endcase
    end

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (bus.i_funct3),
        .op_a   (op1),
        .op_b   (op2),
        .taken  (cond)
    );

    assign taken     = bus.i_jal | bus.i_jalr | (bus.i_br & cond);
    assign resolving = (state_reg == ST_RESOLVE) & act & (need == 2'd0);

    assign bus.o_stall      = act & ((state_reg == ST_STALL) | (need != 2'd0));
    assign bus.o_redirect   = taken & resolving;
    assign bus.o_flush_ifid = taken & resolving;
    assign bus.o_target     = bus.i_jalr ? ((op1 + bus.i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                         : (bus.i_ifid_pc + bus.i_imm);
    assign bus.o_br_cnt     = br_cnt_reg;
    assign bus.o_taken_cnt  = taken_cnt_reg;

    // scnt holds the stall cycles still owed after the current one; the
    // hazard-detect cycle itself is the first stall cycle.
    always_comb begin
        state_next = state_reg;
        scnt_next  = scnt_reg;
        case (state_reg)
            ST_RESOLVE: begin
                if (act && need != 2'd0) begin
                    scnt_next  = need - 2'd1;
                    state_next = (need == 2'd1) ? ST_RESOLVE : ST_STALL;
                end
            end
            ST_STALL: begin
                if (scnt_reg <= 2'd1) begin
                    scnt_next  = 2'd0;
                    state_next = ST_RESOLVE;
                end else begin
                    scnt_next = scnt_reg - 2'd1;
                end
            end
            default: begin
                state_next = ST_RESOLVE;
                scnt_next  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_RESOLVE;
            scnt_reg      <= 2'd0;
            br_cnt_reg    <= '0;
            taken_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            scnt_reg  <= scnt_next;
            if (resolving)
                br_cnt_reg <= br_cnt_reg + 1'b1;
            if (resolving && taken)
                taken_cnt_reg <= taken_cnt_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
    import pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic i_clk;
    logic i_reset;
    int   total;
    int   bad;

    branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle();
        bus.i_ifid_valid    = 1'b0;
        bus.i_ifid_pc       = '0;
        bus.i_br            = 1'b0;
        bus.i_jal           = 1'b0;
        bus.i_jalr          = 1'b0;
        bus.i_funct3        = 3'b000;
        bus.i_imm           = '0;
        bus.i_rs1_data      = '0;
        bus.i_rs2_data      = '0;
        bus.i_rs1_brsel     = BRSEL_RF;
        bus.i_rs2_brsel     = BRSEL_RF;
        bus.i_idex_alu_data = '0;
        bus.i_idex_memrd    = 1'b0;
        bus.i_exmem_data    = '0;
        bus.i_exmem_memrd   = 1'b0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2);
        idle();
        bus.i_ifid_valid = 1'b1;
        bus.i_br         = 1'b1;
        bus.i_funct3     = f3;
        bus.i_ifid_pc    = pc;
        bus.i_imm        = imm;
        bus.i_rs1_data   = rs1;
        bus.i_rs2_data   = rs2;
    endtask

    // advance one cycle; inputs change #1 after the edge, checks at negedge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        at_neg();
        check("rst_stall", 64'(bus.o_stall), 64'd0);
        check("rst_redirect", 64'(bus.o_redirect), 64'd0);
        check("rst_br_cnt", 64'(bus.o_br_cnt), 64'd0);
        check("rst_taken_cnt", 64'(bus.o_taken_cnt), 64'd0);

        // Non-active instruction with a load hazard pattern: no stall
        step();
        bus.i_br = 1'b1; bus.i_rs1_brsel = BRSEL_EX; bus.i_idex_memrd = 1'b1;
        at_neg();
        check("bubble_stall", 64'(bus.o_stall), 64'd0);

        // BEQ 5==5 from regfile
        step();
        branch(F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5);
        at_neg();
        check("beq_redirect", 64'(bus.o_redirect), 64'd1);
        check("beq_flush", 64'(bus.o_flush_ifid), 64'd1);
        check("beq_target", 64'(bus.o_target), 64'h120);
        check("beq_stall", 64'(bus.o_stall), 64'd0);
        step();
        idle();
        at_neg();
        check("beq_br_cnt", 64'(bus.o_br_cnt), 64'd1);
        check("beq_taken_cnt", 64'(bus.o_taken_cnt), 64'd1);

        // BLT -1 < 1 signed via EX forward
        step();
        branch(F3_BLT, 32'h200, 32'h10, 32'd0, 32'd1);
        bus.i_rs1_brsel = BRSEL_EX; bus.i_idex_alu_data = 32'hFFFF_FFFF;
        at_neg();
        check("blt_redirect", 64'(bus.o_redirect), 64'd1);
        check("blt_target", 64'(bus.o_target), 64'h210);
        step();
        bus.i_funct3 = F3_BLTU;
        at_neg();
        check("bltu_redirect", 64'(bus.o_redirect), 64'd0);
        step();
        idle();
        at_neg();
        check("blt_br_cnt", 64'(bus.o_br_cnt), 64'd3);
        check("blt_taken_cnt", 64'(bus.o_taken_cnt), 64'd2);

        // Load in EX feeding rs1: 2 stall cycles then resolve
        step();
        branch(F3_BEQ, 32'h400, 32'h8, 32'd0, 32'd7);
        bus.i_rs1_brsel = BRSEL_EX; bus.i_idex_memrd = 1'b1;
        at_neg();
        check("ldex_stall1", 64'(bus.o_stall), 64'd1);
        check("ldex_redir1", 64'(bus.o_redirect), 64'd0);
        step();
        at_neg();
        check("ldex_stall2", 64'(bus.o_stall), 64'd1);
        check("ldex_cnt_hold", 64'(bus.o_br_cnt), 64'd3);
        step();
        bus.i_rs1_brsel = BRSEL_RF; bus.i_idex_memrd = 1'b0; bus.i_rs1_data = 32'd7;
        at_neg();
        check("ldex_stall3", 64'(bus.o_stall), 64'd0);
        check("ldex_redirect", 64'(bus.o_redirect), 64'd1);
        check("ldex_target", 64'(bus.o_target), 64'h408);
        step();
        idle();
        at_neg();
        check("ldex_br_cnt", 64'(bus.o_br_cnt), 64'd4);
        check("ldex_taken_cnt", 64'(bus.o_taken_cnt), 64'd3);

        // Load in MEM feeding rs2: 1 stall cycle then resolve (BNE 3!=3 false)
        step();
        branch(F3_BNE, 32'h500, 32'h8, 32'd3, 32'd0);
        bus.i_rs2_brsel = BRSEL_MEM; bus.i_exmem_memrd = 1'b1;
        at_neg();
        check("ldmem_stall1", 64'(bus.o_stall), 64'd1);
        step();
        bus.i_rs2_brsel = BRSEL_RF; bus.i_exmem_memrd = 1'b0; bus.i_rs2_data = 32'd3;
        at_neg();
        check("ldmem_stall2", 64'(bus.o_stall), 64'd0);
        check("ldmem_redirect", 64'(bus.o_redirect), 64'd0);
        step();
        idle();
        at_neg();
        check("ldmem_br_cnt", 64'(bus.o_br_cnt), 64'd5);
        check("ldmem_taken_cnt", 64'(bus.o_taken_cnt), 64'd3);

        // JALR rs1=0x1003 from MEM forward, imm=4 -> 0x1006 (bit0 cleared)
        step();
        idle();
        bus.i_ifid_valid = 1'b1; bus.i_jalr = 1'b1; bus.i_imm = 32'd4;
        bus.i_rs1_brsel = BRSEL_MEM; bus.i_exmem_data = 32'h1003;
        at_neg();
        check("jalr_redirect", 64'(bus.o_redirect), 64'd1);
        check("jalr_target", 64'(bus.o_target), 64'h1006);
        // JAL with EX load hazard pattern: no stall, target wraps
        step();
        idle();
        bus.i_ifid_valid = 1'b1; bus.i_jal = 1'b1;
        bus.i_ifid_pc = 32'hFFFF_FFF0; bus.i_imm = 32'h20;
        bus.i_rs1_brsel = BRSEL_EX; bus.i_rs2_brsel = BRSEL_EX; bus.i_idex_memrd = 1'b1;
        at_neg();
        check("jal_stall", 64'(bus.o_stall), 64'd0);
        check("jal_redirect", 64'(bus.o_redirect), 64'd1);
        check("jal_target_wrap", 64'(bus.o_target), 64'h10);
        step();
        idle();
        at_neg();
        check("jump_br_cnt", 64'(bus.o_br_cnt), 64'd7);
        check("jump_taken_cnt", 64'(bus.o_taken_cnt), 64'd5);

        // Reset while in STALL
        step();
        branch(F3_BEQ, 32'h600, 32'h8, 32'd0, 32'd0);
        bus.i_rs1_brsel = BRSEL_EX; bus.i_idex_memrd = 1'b1;
        step();
        at_neg();
        check("rststall_in", 64'(bus.o_stall), 64'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        branch(3'b010, 32'h700, 32'h8, 32'd9, 32'd9);
        at_neg();
        check("rststall_stall", 64'(bus.o_stall), 64'd0);
        check("rststall_redirect", 64'(bus.o_redirect), 64'd0);
        check("rststall_br_cnt", 64'(bus.o_br_cnt), 64'd0);
        check("rststall_taken_cnt", 64'(bus.o_taken_cnt), 64'd0);
        step();
        idle();
        at_neg();
        check("f3_010_br_cnt", 64'(bus.o_br_cnt), 64'd1);
        check("f3_010_taken_cnt", 64'(bus.o_taken_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
ID-stage branch/jump resolution unit. It consumes the per-operand branch forwarding selects and the operand sources (register file, EX ALU result, MEM result). It then compares the operands, computes the target, and drives the PC redirect and IF/ID flush. A small stall FSM holds the front end while a load producer is still in flight. Taken/resolved performance counters are included.

Parameters:
XLEN, 32, datapath/address width
CNT_W, 32, width of performance counters

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_ifid_valid  in  1  IF/ID holds a real instruction (not bubble)
i_ifid_pc  in  XLEN  PC of instruction in ID
i_br  in  1  instruction is conditional branch
i_jal  in  1  instruction is JAL
i_jalr  in  1  instruction is JALR
i_funct3  in  3  branch condition code
i_imm  in  XLEN  sign-extended B/J/I immediate
i_rs1_data  in  XLEN  register file rs1 read (write-through)
i_rs2_data  in  XLEN  register file rs2 read (write-through)
i_rs1_brsel  in  2  rs1 source: 00 regfile, 01 EX, 10 MEM, 11 regfile
i_rs2_brsel  in  2  rs2 source, same encoding
i_idex_alu_data  in  XLEN  EX-stage ALU result
i_idex_memrd  in  1  instruction in EX is a load
i_exmem_data  in  XLEN  EX/MEM stored ALU result
i_exmem_memrd  in  1  instruction in MEM is a load
o_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
o_redirect  out  1  PC mux selects o_target
o_target  out  XLEN  redirect address
o_flush_ifid  out  1  IF/ID loads a bubble at next edge
o_br_cnt  out  CNT_W  resolved control-transfer count
o_taken_cnt  out  CNT_W  taken count

Behaviour:
- Active instruction: act = i_ifid_valid & (i_br | i_jal | i_jalr). JAL uses no operands and never stalls.
- Operand use: rs1 is used by br/jalr; rs2 is used by br only.
- Load hazard, per used operand:
  - brsel=01 with i_idex_memrd: needs 2 stall cycles.
  - brsel=10 with i_exmem_memrd: needs 1 stall cycle.
  - If both operands hit, the maximum applies.
- FSM states: RESOLVE, STALL. 2-bit stall counter scnt.
  - RESOLVE, act and need>0: o_stall=1 this cycle. Go to STALL with scnt=need-1. If need-1==0, return straight to RESOLVE. No redirect and no counting this cycle.
  - STALL: o_stall=1. Brsel/memrd inputs are ignored. scnt decrements. Leave for RESOLVE when scnt==0 at the edge.
  - RESOLVE, no hazard: resolve combinationally in the same cycle; o_stall=0.
- After a stall, the producer is in WB or beyond. brsel then reads 00, and the write-through regfile supplies the value.
- Operand mux: 01→i_idex_alu_data, 10→i_exmem_data, 00/11→i_rsX_data.
- Conditions by funct3:
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - 010/011: not taken
- Taken = jal | jalr | (br & cond).
- Target:
  - br/jal: i_ifid_pc + i_imm, modulo 2^XLEN.
  - jalr: (rs1 + i_imm) with bit0 cleared.
- Redirect outputs: o_redirect = o_flush_ifid = taken & resolving (RESOLVE, act, no hazard). These are combinational; branch penalty is 1 cycle.
- o_target is driven at all times; it is meaningful only when o_redirect=1.
- o_stall is 0 whenever act=0.
- Counters, registered:
  - o_br_cnt +1 per resolving cycle.
  - o_taken_cnt +1 per resolving cycle with taken.
  - Both wrap at 2^CNT_W.
- Reset: state RESOLVE, scnt=0, counters 0. Combinational outputs become 0 for a non-active instruction.
- Reset asserted mid-STALL: o_stall deasserts in the cycle after the reset edge. No pending resolve is remembered.

Decomposition:
- Shared package pipe_pkg:
  - brsel encoding constants (BRSEL_RF, BRSEL_EX, BRSEL_MEM).
  - funct3 branch codes.
  - FSM state enum.
- One natural sub-module: branch_cmp (combinational; funct3 + two operands → taken).

Test Plan:
- BEQ, rs1=rs2=5 from regfile (brsel 00), pc=0x100, imm=0x20 → o_redirect=1, o_target=0x120, o_stall=0, both counters =1.
- BLT, rs1 via brsel=01, i_idex_alu_data=0xFFFFFFFF (−1), rs2=1; then BLTU with the same operands → BLT taken, BLTU not taken, o_taken_cnt +1 only.
- Branch with rs1 brsel=01 and i_idex_memrd=1 → o_stall=1 for exactly 2 cycles. Third cycle, brsel=00 with regfile data → resolves once, o_br_cnt +1.
- rs2 brsel=10 with i_exmem_memrd=1 → exactly 1 stall cycle, then resolve.
- JALR rs1=0x1003 via brsel=10, imm=4 → o_target=0x1006, taken. JAL with i_idex_memrd=1 and matching brsel → no stall.
- Reset asserted in STALL (after first of 2 cycles) → next cycle o_stall=0, counters 0. funct3=010 → not taken.
